exec_alu_pipe: RTL and testbench

Parametrised, registered successor to the single-cycle execute-stage ALU. It accepts one operation per cycle through a valid/ready handshake and registers the result. It owns the condition-code register (CCR) and supports flush and CCR restore. It sits between the ID/EX and EX/MEM pipeline registers, and its result and status feed forwarding and writeback.

---
 rtl/exec_alu_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_exec_alu_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/exec_alu_pipe.sv
`default_nettype none
// ============================================================================
// exec_alu_pipe : registered execute-stage ALU owning the CCR (flush, restore)
// Rev 1.0       : optional iterative shift-add multiply under EXEC_MUL_EN
// ============================================================================
module exec_alu_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [SHAMT_W-1:0] imm,
  input  logic               flush,
  input  logic               status_load,
  input  logic [3:0]         status_in,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic [3:0]         status,
  output logic               busy
);

  localparam logic [3:0] c_OP_ADD   = 4'b0000;
  localparam logic [3:0] c_OP_SUB   = 4'b0001;
  localparam logic [3:0] c_OP_AND   = 4'b0010;
  localparam logic [3:0] c_OP_OR    = 4'b0011;
  localparam logic [3:0] c_OP_SHL   = 4'b0100;
  localparam logic [3:0] c_OP_SHR   = 4'b0101;
  localparam logic [3:0] c_OP_NOT   = 4'b0110;
  localparam logic [3:0] c_OP_PASSB = 4'b0111;
  localparam logic [3:0] c_OP_INC   = 4'b1000;
  localparam logic [3:0] c_OP_DEC   = 4'b1001;
  localparam logic [3:0] c_OP_PASSA = 4'b1010;
  localparam logic [3:0] c_OP_SETC  = 4'b1100;
  localparam logic [3:0] c_OP_CLRC  = 4'b1101;
  localparam int         c_MSB      = WIDTH - 1;

  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       ccr_q, ccr_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_ccr;
  logic             w_zn;
  logic             w_accept;
  logic [WIDTH:0]   w_add, w_sub, w_inc, w_dec, w_shl, w_shr;

  // Single-cycle datapath: w_res defaults to the held result, w_ccr to the held CCR.
  always_comb begin
    w_add = {1'b0, src_a} + {1'b0, src_b};
    w_sub = {1'b0, src_b} - {1'b0, src_a};
    w_inc = {1'b0, src_a} + (WIDTH+1)'(1);
    w_dec = {1'b0, src_a} - (WIDTH+1)'(1);
    w_shl = {1'b0, src_a} << imm;
    w_shr = {src_a, 1'b0} >> imm;
    w_res = result_q;
    w_ccr = ccr_q;
    w_zn  = 1'b0;
    case (alu_ctrl)
      c_OP_ADD: begin
        w_res    = w_add[WIDTH-1:0];
        w_zn     = 1'b1;
        w_ccr[2] = w_add[WIDTH];
        w_ccr[3] = (src_a[c_MSB] == src_b[c_MSB]) && (w_add[c_MSB] != src_a[c_MSB]);
      end
      c_OP_SUB: begin
        w_res    = w_sub[WIDTH-1:0];
        w_zn     = 1'b1;
        w_ccr[2] = w_sub[WIDTH];
        w_ccr[3] = (src_a[c_MSB] != src_b[c_MSB]) && (w_sub[c_MSB] != src_b[c_MSB]);
      end
      c_OP_AND: begin
        w_res = src_a & src_b;
        w_zn  = 1'b1;
      end
      c_OP_OR: begin
        w_res = src_a | src_b;
        w_zn  = 1'b1;
      end
      c_OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_zn  = 1'b1;
        if (imm != '0) w_ccr[2] = w_shl[WIDTH];
      end
      c_OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_zn  = 1'b1;
        if (imm != '0) w_ccr[2] = w_shr[0];
      end
      c_OP_NOT: begin
        w_res = ~src_a;
        w_zn  = 1'b1;
      end
      c_OP_PASSB: w_res = src_b;
      c_OP_INC: begin
        w_res    = w_inc[WIDTH-1:0];
        w_zn     = 1'b1;
        w_ccr[2] = w_inc[WIDTH];
        w_ccr[3] = !src_a[c_MSB] && w_inc[c_MSB];
      end
      c_OP_DEC: begin
        w_res    = w_dec[WIDTH-1:0];
        w_zn     = 1'b1;
        w_ccr[2] = w_dec[WIDTH];
        w_ccr[3] = src_a[c_MSB] && !w_dec[c_MSB];
      end
      c_OP_PASSA: w_res = src_a;
      c_OP_SETC:  w_ccr[2] = 1'b1;
      c_OP_CLRC:  w_ccr[2] = 1'b0;
      default: ;
    endcase
    if (w_zn) begin
      w_ccr[0] = (w_res == '0);
      w_ccr[1] = w_res[c_MSB];
    end
  end

`ifdef EXEC_MUL_EN
  localparam logic [3:0] c_OP_MUL = 4'b1011;
  localparam int         c_PW     = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_RUN  = 2'd1,
    S_MUL_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [c_PW-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]      w_mul_sum;
  logic [c_PW-1:0]     w_mul_next;

  assign busy = (state_q == S_MUL_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign busy = 1'b0;
`endif

  assign in_ready = !busy;
  assign w_accept = in_valid && in_ready && !flush;

  always_comb begin
    result_d    = result_q;
    ccr_d       = ccr_q;
    out_valid_d = 1'b0;
`ifdef EXEC_MUL_EN
    state_d = state_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    // Product register holds {partial sum, unconsumed multiplier bits}.
    w_mul_sum  = {1'b0, prod_q[c_PW-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    w_mul_next = {w_mul_sum, prod_q[WIDTH-1:1]};
    case (state_q)
      S_MUL_RUN: begin
        prod_d = w_mul_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
          state_d     = S_MUL_DONE;
          out_valid_d = 1'b1;
          result_d    = w_mul_next[WIDTH-1:0];
          ccr_d[0]    = (w_mul_next[WIDTH-1:0] == '0);
          ccr_d[1]    = w_mul_next[WIDTH-1];
          ccr_d[2]    = |w_mul_next[c_PW-1:WIDTH];
        end
      end
      default: begin
        state_d = S_IDLE;
        if (w_accept) begin
          if (alu_ctrl == c_OP_MUL) begin
            state_d = S_MUL_RUN;
            prod_d  = {{WIDTH{1'b0}}, src_b};
            mcand_d = src_a;
            cnt_d   = '0;
          end else begin
            out_valid_d = 1'b1;
            result_d    = w_res;
            ccr_d       = w_ccr;
          end
        end
      end
    endcase
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
      ccr_d       = ccr_q;
    end
`else
    if (w_accept) begin
      out_valid_d = 1'b1;
      result_d    = w_res;
      ccr_d       = w_ccr;
    end
`endif
    // CCR restore overrides both flush and any flag update on the same edge.
    if (status_load) ccr_d = status_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      ccr_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      ccr_q       <= ccr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign status    = ccr_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_alu_pipe.sv
`default_nettype none
// ============================================================================
// tb_exec_alu_pipe : directed-vector bench for exec_alu_pipe (WIDTH=16)
// Rev 1.0          : multiply vectors compiled in under EXEC_MUL_EN
// ============================================================================
module tb_exec_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic [3:0]  imm;
  logic        flush;
  logic        status_load;
  logic [3:0]  status_in;
  logic        out_valid;
  logic [15:0] result;
  logic [3:0]  status;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  exec_alu_pipe #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_ctrl    (alu_ctrl),
    .src_a       (src_a),
    .src_b       (src_b),
    .imm         (imm),
    .flush       (flush),
    .status_load (status_load),
    .status_in   (status_in),
    .out_valid   (out_valid),
    .result      (result),
    .status      (status),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic [15:0] res,
                            input logic [3:0] st);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".result"},    32'(result),    32'(res));
    chk({tag, ".status"},    32'(status),    32'(st));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                    input logic [3:0] sh);
    alu_ctrl = c;
    src_a    = a;
    src_b    = b;
    imm      = sh;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    logic ready_seen, ov_seen;

    rst = 1'b1; in_valid = 1'b0; alu_ctrl = 4'h0; src_a = '0; src_b = '0; imm = '0;
    flush = 1'b0; status_load = 1'b0; status_in = 4'h0;
    tick(); tick();
    rst = 1'b0;
    expect_out("reset", 1'b0, 16'h0000, 4'h0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    op(4'b0000, 16'd5, 16'd6, 4'd0);          expect_out("add5_6", 1'b1, 16'd11, 4'h0);
    tick();                                   chk("add.pulse", 32'(out_valid), 32'd0);
    op(4'b0000, 16'h800F, 16'h800F, 4'd0);    expect_out("add_ovf", 1'b1, 16'h001E, 4'hC);
    op(4'b0001, 16'd2, 16'd5, 4'd0);          expect_out("sub_2_5", 1'b1, 16'd3, 4'h0);
    op(4'b0001, 16'd5, 16'd5, 4'd0);          expect_out("sub_5_5", 1'b1, 16'd0, 4'h1);
    op(4'b0001, 16'd6, 16'd5, 4'd0);          expect_out("sub_6_5", 1'b1, 16'hFFFF, 4'h6);
    op(4'b0100, 16'hC00F, 16'd0, 4'd2);       expect_out("shl2", 1'b1, 16'h003C, 4'h4);
    op(4'b1101, 16'd0, 16'd0, 4'd0);          expect_out("clrc", 1'b1, 16'h003C, 4'h0);
    op(4'b0101, 16'h000F, 16'd0, 4'd2);       expect_out("shr2", 1'b1, 16'h0003, 4'h4);
    op(4'b0010, 16'h00F0, 16'h0F0F, 4'd0);    expect_out("and", 1'b1, 16'h0000, 4'h5);
    op(4'b1101, 16'd0, 16'd0, 4'd0);          expect_out("clrc2", 1'b1, 16'h0000, 4'h1);
    op(4'b1100, 16'd0, 16'd0, 4'd0);          expect_out("setc", 1'b1, 16'h0000, 4'h5);
    op(4'b0100, 16'h8001, 16'd0, 4'd0);       expect_out("shl0", 1'b1, 16'h8001, 4'h6);
    op(4'b0011, 16'h00F0, 16'h0F00, 4'd0);    expect_out("or", 1'b1, 16'h0FF0, 4'h4);
    op(4'b0110, 16'h00FF, 16'd0, 4'd0);       expect_out("not", 1'b1, 16'hFF00, 4'h6);
    op(4'b0111, 16'd0, 16'h1234, 4'd0);       expect_out("passb", 1'b1, 16'h1234, 4'h6);

    op(4'b1000, 16'd0, 16'd0, 4'd0);          expect_out("b2b_inc", 1'b1, 16'd1, 4'h0);
    op(4'b1001, 16'd1, 16'd0, 4'd0);          expect_out("b2b_dec", 1'b1, 16'd0, 4'h1);
    op(4'b1010, 16'd0, 16'd0, 4'd0);          expect_out("b2b_passa", 1'b1, 16'd0, 4'h1);

    op(4'b1000, 16'hFFFF, 16'd0, 4'd0);       expect_out("inc_wrap", 1'b1, 16'h0000, 4'h5);
    op(4'b1001, 16'h8000, 16'd0, 4'd0);       expect_out("dec_ovf", 1'b1, 16'h7FFF, 4'h8);
    op(4'b1001, 16'h0000, 16'd0, 4'd0);       expect_out("dec_wrap", 1'b1, 16'hFFFF, 4'h6);
    op(4'b0000, 16'h7FFF, 16'h0001, 4'd0);    expect_out("add_posovf", 1'b1, 16'h8000, 4'hA);
    op(4'b1111, 16'h1111, 16'h2222, 4'd3);    expect_out("nop", 1'b1, 16'h8000, 4'hA);
`ifndef EXEC_MUL_EN
    op(4'b1011, 16'd3, 16'd5, 4'd0);          expect_out("mul_as_nop", 1'b1, 16'h8000, 4'hA);
    chk("mul_as_nop.busy", 32'(busy), 32'd0);
`endif

    status_load = 1'b1; status_in = 4'h9;
    op(4'b0000, 16'd1, 16'd1, 4'd0);          expect_out("restore_add", 1'b1, 16'd2, 4'h9);
    status_load = 1'b0;
    flush = 1'b1;
    op(4'b0000, 16'd3, 16'd4, 4'd0);          expect_out("flush_op", 1'b0, 16'd2, 4'h9);
    status_load = 1'b1; status_in = 4'h3;
    op(4'b0000, 16'd3, 16'd4, 4'd0);          expect_out("flush_restore", 1'b0, 16'd2, 4'h3);
    status_load = 1'b0; flush = 1'b0;
    op(4'b0000, 16'd3, 16'd4, 4'd0);          expect_out("after_flush", 1'b1, 16'd7, 4'h0);

`ifdef EXEC_MUL_EN
    op(4'b1011, 16'd300, 16'd300, 4'd0);
    alu_ctrl = 4'b0111; src_b = 16'h1111; in_valid = 1'b1;
    busy_cnt = 0; ready_seen = 1'b0; ov_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      busy_cnt += int'(busy);
      ready_seen |= in_ready;
      ov_seen    |= out_valid;
      tick();
    end
    in_valid = 1'b0;
    chk("mul.busy_cycles", 32'(busy_cnt), 32'd16);
    chk("mul.ready_while_busy", 32'(ready_seen), 32'd0);
    chk("mul.early_valid", 32'(ov_seen), 32'd0);
    expect_out("mul_done", 1'b1, 16'h5F90, 4'h4);
    chk("mul_done.busy", 32'(busy), 32'd0);
    tick();                                   expect_out("mul_after", 1'b0, 16'h5F90, 4'h4);

    op(4'b1011, 16'd300, 16'd300, 4'd0);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("mul_flush.busy", 32'(busy), 32'd0);
    ov_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ov_seen |= out_valid;
      tick();
    end
    chk("mul_flush.no_valid", 32'(ov_seen), 32'd0);
    expect_out("mul_flush", 1'b0, 16'h5F90, 4'h4);

    op(4'b1011, 16'd3, 16'd5, 4'd0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("mul_rst", 1'b0, 16'h0000, 4'h0);
    chk("mul_rst.busy", 32'(busy), 32'd0);
    chk("mul_rst.in_ready", 32'(in_ready), 32'd1);
    ov_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ov_seen |= out_valid;
      tick();
    end
    chk("mul_rst.no_valid", 32'(ov_seen), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
